// File: rtl/one_wire_rom_collector.sv
// one_wire_rom_collector: gathers eight received 1-Wire bytes into a 64-bit
// ROM ID, runs a bit-serial Dallas/Maxim CRC-8 over them and reports the
// frame to the host. Partial frames are aborted on inter-byte timeout or clear.
module one_wire_rom_collector #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        clear,
  output logic        frame_valid,
  output logic        crc_ok,
  output logic [63:0] rom_id,
  output logic [7:0]  family_code,
  output logic [3:0]  byte_count,
  output logic        busy,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam int unsigned GW = $clog2(TIMEOUT_CYCLES + 1);
  // Timeout fires on the idle cycle whose increment would reach TIMEOUT_CYCLES.
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;

  state_t        state;
  logic [7:0]    shreg;
  logic [7:0]    crc;
  logic [2:0]    bitcnt;
  logic [GW-1:0] gapcnt;
  logic [63:0]   frame;

  // One step of the reflected 0x8C CRC, LSB first.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[0] ^ b;
    return (c >> 1) ^ (fb ? 8'h8C : 8'h00);
  endfunction

  assign family_code = rom_id[7:0];
  assign busy        = (state != IDLE) || (byte_count != 4'd0);

  // Frame assembly FSM: byte capture, serial CRC, report, timeout and overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      crc         <= '0;
      bitcnt      <= '0;
      gapcnt      <= '0;
      frame       <= '0;
      byte_count  <= '0;
      rom_id      <= '0;
      crc_ok      <= 1'b0;
      frame_valid <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        byte_count <= '0;
        crc        <= '0;
        gapcnt     <= '0;
        bitcnt     <= '0;
      end else begin
        if (rx_valid && state != IDLE) begin
          err_overrun <= 1'b1;
        end
        case (state)
          IDLE: begin
            if (rx_valid) begin
              frame[{byte_count[2:0], 3'b000} +: 8] <= rx_byte;
              shreg  <= rx_byte;
              if (byte_count == 4'd0) begin
                crc <= '0;
              end
              gapcnt <= '0;
              bitcnt <= '0;
              state  <= SHIFT;
            end else if (byte_count != 4'd0) begin
              if (gapcnt == GAP_LAST) begin
                err_timeout <= 1'b1;
                byte_count  <= '0;
                crc         <= '0;
                gapcnt      <= '0;
              end else begin
                gapcnt <= gapcnt + GAP_ONE;
              end
            end
          end
          SHIFT: begin
            crc    <= crc_step(crc, shreg[0]);
            shreg  <= shreg >> 1;
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              byte_count <= byte_count + 4'd1;
              state      <= (byte_count == 4'd7) ? REPORT : IDLE;
            end
          end
          REPORT: begin
            rom_id      <= frame;
            crc_ok      <= (crc == 8'h00);
            frame_valid <= 1'b1;
            byte_count  <= '0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_one_wire_rom_collector.sv
// Testbench for one_wire_rom_collector: table of frames pushed through a
// scoreboard, plus sequences for timeout, overrun, clear and mid-frame reset.
module tb_one_wire_rom_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        clear = 1'b0;
  logic        frame_valid, crc_ok, busy, err_timeout, err_overrun;
  logic [63:0] rom_id;
  logic [7:0]  family_code;
  logic [3:0]  byte_count;

  one_wire_rom_collector #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .clear(clear), .frame_valid(frame_valid), .crc_ok(crc_ok),
    .rom_id(rom_id), .family_code(family_code), .byte_count(byte_count),
    .busy(busy), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] rom; logic ok; } vec_t;
  typedef struct { logic [63:0] rom; logic ok; int unsigned due; } exp_t;

  localparam logic [63:0] GOOD = 64'hA2000000_01B81C02;
  localparam logic [63:0] BAD  = 64'hA3000000_01B81C02;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned last_k = 0;
  int unsigned ovr_cnt = 0, ovr_cyc = 0;
  int unsigned to_cnt = 0, to_cyc = 0;
  exp_t        sbq[$];
  exp_t        e;
  vec_t        vt[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc_model(input logic [63:0] d, input int unsigned nbytes);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int unsigned i = 0; i < nbytes * 8; i++) begin
      fb = c[0] ^ d[i];
      c = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  // Scoreboard monitor: pops an expected frame on every frame_valid cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: got rom_id %h at cycle %0d, want no frame", rom_id, cyc);
        end else begin
          e = sbq.pop_front();
          check("rom_id", rom_id, e.rom);
          check("crc_ok", 64'(crc_ok), 64'(e.ok));
          check("family_code", 64'(family_code), 64'(e.rom[7:0]));
          check("frame_latency", 64'(cyc), 64'(e.due));
        end
      end
      if (err_overrun) begin ovr_cnt++; ovr_cyc = cyc; end
      if (err_timeout) begin to_cnt++; to_cyc = cyc; end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    last_k = cyc;
  endtask

  task automatic gap(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bytes spaced 20 clocks apart; expectation queued with the last strobe.
  task automatic send_frame(input logic [63:0] rom, input logic ok);
    exp_t x;
    for (int unsigned i = 0; i < 8; i++) begin
      send_byte(rom[8*i +: 8]);
      if (i == 7) begin
        x.rom = rom; x.ok = ok; x.due = last_k + 9;
        sbq.push_back(x);
      end
      gap(18);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  initial begin
    int unsigned k3, prev_ovr;
    logic [63:0] r;
    exp_t x;

    // table of frames: the known good/bad IDs, random IDs and all-zero/all-ones
    vt[0] = '{GOOD, 1'b1};
    vt[1] = '{BAD, 1'b0};
    r = {8'h00, $urandom(), $urandom()} & 64'h00FF_FFFF_FFFF_FFFF;
    r[63:56] = crc_model(r, 7);
    vt[2] = '{r, 1'b1};
    r[63:56] = r[63:56] ^ 8'h10;
    vt[3] = '{r, 1'b0};
    vt[4] = '{64'h0, 1'b1};
    vt[5] = '{64'hFFFF_FFFF_FFFF_FFFF, (crc_model(64'hFFFF_FFFF_FFFF_FFFF, 8) == 8'h00)};

    gap(3);
    check("reset_outputs", {56'(0), frame_valid, crc_ok, err_timeout, err_overrun, busy, byte_count[2:0]}, 64'd0);
    check("reset_rom_id", rom_id, 64'd0);
    check("reset_family", 64'(family_code), 64'd0);
    rst_n = 1'b1;
    gap(2);

    for (int unsigned i = 0; i < 6; i++) send_frame(vt[i].rom, vt[i].ok);
    gap(5);

    // timeout: 3 bytes then silence; pulse 100 clocks after the 3rd byte returns to IDLE
    send_byte(8'h02); gap(18);
    send_byte(8'h1C); gap(18);
    send_byte(8'hB8);
    k3 = last_k;
    for (int unsigned t = 0; t < 200 && to_cnt == 0; t++) gap(1);
    check("timeout_seen", 64'(to_cnt), 64'd1);
    check("timeout_cycle", 64'(to_cyc), 64'(k3 + 108));
    check("timeout_byte_count", 64'(byte_count), 64'd0);
    check("timeout_busy", 64'(busy), 64'd0);
    send_frame(GOOD, 1'b1);

    // overrun: extra strobe 4 clocks after byte 2 (index 2)
    prev_ovr = ovr_cnt;
    for (int unsigned i = 0; i < 8; i++) begin
      send_byte(GOOD[8*i +: 8]);
      if (i == 2) begin
        k3 = last_k;
        repeat (3) @(posedge clk);
        #1; rx_valid = 1'b1; rx_byte = 8'h55;
        @(posedge clk); #1; rx_valid = 1'b0;
        gap(4);
        check("overrun_pulse", 64'(ovr_cnt - prev_ovr), 64'd1);
        check("overrun_cycle", 64'(ovr_cyc), 64'(k3 + 4));
        check("overrun_byte_count", 64'(byte_count), 64'd3);
      end
      if (i == 7) begin
        x.rom = GOOD; x.ok = 1'b1; x.due = last_k + 9;
        sbq.push_back(x);
      end
      gap(18);
    end

    // clear after byte 5, coinciding with a strobe that must be dropped silently
    send_frame(BAD, 1'b0);
    gap(5);
    prev_ovr = ovr_cnt;
    for (int unsigned i = 0; i < 5; i++) begin send_byte(GOOD[8*i +: 8]); gap(18); end
    check("pre_clear_byte_count", 64'(byte_count), 64'd5);
    @(posedge clk); #1;
    clear = 1'b1; rx_valid = 1'b1; rx_byte = 8'h77;
    @(posedge clk); #1;
    clear = 1'b0; rx_valid = 1'b0;
    gap(3);
    check("clear_byte_count", 64'(byte_count), 64'd0);
    check("clear_busy", 64'(busy), 64'd0);
    check("clear_no_overrun", 64'(ovr_cnt - prev_ovr), 64'd0);
    check("clear_rom_held", rom_id, BAD);
    check("clear_crc_held", 64'(crc_ok), 64'd0);
    send_frame(GOOD, 1'b1);

    // reset during SHIFT of byte 4
    for (int unsigned i = 0; i < 4; i++) begin
      send_byte(BAD[8*i +: 8]);
      if (i < 3) gap(18);
    end
    gap(3);
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", {56'(0), frame_valid, crc_ok, err_timeout, err_overrun, busy, byte_count[2:0]}, 64'd0);
    check("midreset_rom_id", rom_id, 64'd0);
    check("midreset_family", 64'(family_code), 64'd0);
    gap(3);
    rst_n = 1'b1;
    gap(2);
    send_frame(GOOD, 1'b1);

    gap(30);
    check("pending_frames", 64'(sbq.size()), 64'd0);
    check("overrun_total", 64'(ovr_cnt), 64'd1);
    check("timeout_total", 64'(to_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
